// File: rtl/eth_phy_10g_rx_block_lock.sv
// 10GBASE-R receive block-lock state machine.
// Watches the 2-bit sync header of each 66b block, declares lock after 64
// consecutive good headers, drops lock after 16 bad headers in a 64-header
// window, and asks the SERDES/gearbox to slip one bit whenever alignment is
// rejected. A saturating count of issued slips is kept for status.
module eth_phy_10g_rx_block_lock #(
    parameter int HDR_WIDTH           = 2,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
    input  logic                 serdes_rx_hdr_valid,
    output logic                 serdes_rx_bitslip,
    output logic                 rx_block_lock,
    output logic [7:0]           rx_slip_count
);

    // Reject illegal parameterisations at elaboration time.
    generate
        if (HDR_WIDTH != 2) begin : g_bad_hdr_width
            $error("eth_phy_10g_rx_block_lock: HDR_WIDTH must be 2");
        end
        if (BITSLIP_HIGH_CYCLES < 1 || BITSLIP_HIGH_CYCLES > 255) begin : g_bad_high
            $error("eth_phy_10g_rx_block_lock: BITSLIP_HIGH_CYCLES must be 1..255");
        end
        if (BITSLIP_LOW_CYCLES < 0 || BITSLIP_LOW_CYCLES > 255) begin : g_bad_low
            $error("eth_phy_10g_rx_block_lock: BITSLIP_LOW_CYCLES must be 0..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_LOCKED    = 2'd1,
        ST_SLIP      = 2'd2,
        ST_SLIP_WAIT = 2'd3
    } state_t;

    // Timer compare points. LOW_LAST is only used when the settle time is non-zero.
    localparam logic [7:0] HIGH_CYC  = 8'(BITSLIP_HIGH_CYCLES);
    localparam logic [7:0] LOW_LAST  = 8'(BITSLIP_LOW_CYCLES - 1);
    localparam bit         SKIP_WAIT = (BITSLIP_LOW_CYCLES == 0);

    state_t     r_state;
    logic [6:0] r_sh_cnt;          // headers seen in the current window, 0..64
    logic [4:0] r_sh_invalid_cnt;  // bad headers in the current window, 0..16
    logic [7:0] r_timer;           // bitslip pulse / settle timer
    logic       r_bitslip;
    logic       r_block_lock;
    logic [7:0] r_slip_count;

    logic       w_hdr_ok;
    logic [6:0] w_sh_cnt_next;
    logic [4:0] w_sh_invalid_next;
    logic       w_window_done;
    logic       w_invalid_limit;

    // A sync header is good only when its two bits differ (01 = data, 10 = control).
    assign w_hdr_ok          = serdes_rx_hdr[1] ^ serdes_rx_hdr[0];
    assign w_sh_cnt_next     = r_sh_cnt + 7'd1;
    assign w_sh_invalid_next = r_sh_invalid_cnt + {4'd0, ~w_hdr_ok};
    assign w_window_done     = (w_sh_cnt_next == 7'd64);
    assign w_invalid_limit   = (w_sh_invalid_next == 5'd16);

    // Lock FSM, header counters, slip pulse timer and registered status outputs.
    // NOTE: every register here uses non-blocking assignment so all of them see
    // the pre-edge values of each other; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_UNLOCKED;
            r_sh_cnt         <= '0;
            r_sh_invalid_cnt <= '0;
            r_timer          <= '0;
            r_bitslip        <= 1'b0;
            r_block_lock     <= 1'b0;
            r_slip_count     <= '0;
        end else begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (serdes_rx_hdr_valid) begin
                        if (!w_hdr_ok) begin
                            r_state          <= ST_SLIP;
                            r_sh_cnt         <= '0;
                            r_sh_invalid_cnt <= '0;
                            r_timer          <= '0;
                        end else if (w_window_done) begin
                            r_state          <= ST_LOCKED;
                            r_block_lock     <= 1'b1;
                            r_sh_cnt         <= '0;
                            r_sh_invalid_cnt <= '0;
                        end else begin
                            r_sh_cnt <= w_sh_cnt_next;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (serdes_rx_hdr_valid) begin
                        // Losing lock wins over a window that completes on the same header.
                        if (w_invalid_limit) begin
                            r_state          <= ST_SLIP;
                            r_block_lock     <= 1'b0;
                            r_sh_cnt         <= '0;
                            r_sh_invalid_cnt <= '0;
                            r_timer          <= '0;
                        end else if (w_window_done) begin
                            r_sh_cnt         <= '0;
                            r_sh_invalid_cnt <= '0;
                        end else begin
                            r_sh_cnt         <= w_sh_cnt_next;
                            r_sh_invalid_cnt <= w_sh_invalid_next;
                        end
                    end
                end

                ST_SLIP: begin
                    // Pulse is raised on the first edge in SLIP and held HIGH_CYC cycles.
                    if (r_timer == HIGH_CYC) begin
                        r_bitslip <= 1'b0;
                        r_timer   <= '0;
                        r_state   <= SKIP_WAIT ? ST_UNLOCKED : ST_SLIP_WAIT;
                    end else begin
                        r_bitslip <= 1'b1;
                        r_timer   <= r_timer + 8'd1;
                        if (r_timer == 8'd0 && r_slip_count != 8'hFF) begin
                            r_slip_count <= r_slip_count + 8'd1;
                        end
                    end
                end

                ST_SLIP_WAIT: begin
                    // Headers are ignored while the gearbox settles on the new alignment.
                    if (r_timer == LOW_LAST) begin
                        r_state          <= ST_UNLOCKED;
                        r_timer          <= '0;
                        r_sh_cnt         <= '0;
                        r_sh_invalid_cnt <= '0;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                default: begin
                    r_state <= ST_UNLOCKED;
                end
            endcase
        end
    end

    assign serdes_rx_bitslip = r_bitslip;
    assign rx_block_lock     = r_block_lock;
    assign rx_slip_count     = r_slip_count;

endmodule

// File: tb/tb_eth_phy_10g_rx_block_lock.sv
// Directed testbench for eth_phy_10g_rx_block_lock.
// A default-parameter instance carries most scenarios; a second instance with a
// 4-cycle bitslip pulse shares the stimulus and is used for mid-pulse reset.
module tb_eth_phy_10g_rx_block_lock;

    logic       clk;
    logic       rst_n;
    logic [1:0] hdr;
    logic       vld;
    logic       bs;
    logic       lock;
    logic [7:0] cnt;
    logic       bs4;
    logic       lock4;
    logic [7:0] cnt4;

    int n_cmp = 0;
    int n_err = 0;

    eth_phy_10g_rx_block_lock #(
        .HDR_WIDTH           (2),
        .BITSLIP_HIGH_CYCLES (1),
        .BITSLIP_LOW_CYCLES  (8)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .serdes_rx_hdr       (hdr),
        .serdes_rx_hdr_valid (vld),
        .serdes_rx_bitslip   (bs),
        .rx_block_lock       (lock),
        .rx_slip_count       (cnt)
    );

    eth_phy_10g_rx_block_lock #(
        .HDR_WIDTH           (2),
        .BITSLIP_HIGH_CYCLES (4),
        .BITSLIP_LOW_CYCLES  (8)
    ) dut4 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .serdes_rx_hdr       (hdr),
        .serdes_rx_hdr_valid (vld),
        .serdes_rx_bitslip   (bs4),
        .rx_block_lock       (lock4),
        .rx_slip_count       (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one header, let one rising edge pass, then settle 1 time unit.
    task automatic send(input logic [1:0] h, input logic v);
        hdr = h;
        vld = v;
        @(posedge clk);
        #1;
    endtask

    // Hold reset over two edges, release it between edges.
    task automatic do_reset();
        rst_n = 1'b0;
        hdr   = 2'b01;
        vld   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        hdr   = 2'b01;
        vld   = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bs, lock, cnt, bs4, lock4, cnt4} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_async: bs=%b lock=%b cnt=%0d bs4=%b lock4=%b cnt4=%0d required all 0",
                     bs, lock, cnt, bs4, lock4, cnt4);
        end
        // Good headers clocked in while reset is held must not count.
        for (int i = 0; i < 70; i++) send(2'b01, 1'b1);
        n_cmp++;
        if ({bs, lock, cnt} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_held: bs=%b lock=%b cnt=%0d required 0 0 0", bs, lock, cnt);
        end
        #2;
        rst_n = 1'b1;
    endtask

    // 64 good headers straight after reset release lock on exactly the 64th.
    task automatic test_lock();
        int early_lock;
        int slips;
        early_lock = 0;
        slips      = 0;
        for (int i = 1; i <= 64; i++) begin
            send((i % 2 == 0) ? 2'b10 : 2'b01, 1'b1);
            if (bs !== 1'b0) slips++;
            if (i < 64 && lock !== 1'b0) early_lock++;
        end
        n_cmp++;
        if (early_lock != 0) begin
            n_err++;
            $display("FAIL lock_early: lock high after %0d of the first 63 samples, required 0", early_lock);
        end
        n_cmp++;
        if (lock !== 1'b1) begin
            n_err++;
            $display("FAIL lock_64: lock=%b after 64th sample, required 1", lock);
        end
        n_cmp++;
        if (slips != 0) begin
            n_err++;
            $display("FAIL lock_no_slip: bitslip seen %0d times, required 0", slips);
        end
    endtask

    // 63 good then one bad header: one slip, 8 ignored cycles, then relock.
    task automatic test_slip();
        int late;
        do_reset();
        for (int i = 0; i < 63; i++) send(2'b01, 1'b1);
        send(2'b11, 1'b1);           // enters SLIP
        n_cmp++;
        if (bs !== 1'b0 || lock !== 1'b0) begin
            n_err++;
            $display("FAIL slip_entry: bs=%b lock=%b, required 0 0", bs, lock);
        end
        send(2'b11, 1'b1);           // pulse cycle
        n_cmp++;
        if (bs !== 1'b1 || cnt !== 8'd1) begin
            n_err++;
            $display("FAIL slip_pulse: bs=%b cnt=%0d, required 1 1", bs, cnt);
        end
        send(2'b11, 1'b1);           // pulse ends, SLIP_WAIT
        n_cmp++;
        if (bs !== 1'b0) begin
            n_err++;
            $display("FAIL slip_pulse_width: bs=%b, required 0", bs);
        end
        // Bad headers inside the settle window must be ignored.
        for (int i = 0; i < 8; i++) send(2'b00, 1'b1);
        late = 0;
        for (int i = 1; i <= 64; i++) begin
            send(2'b01, 1'b1);
            if (i < 64 && lock !== 1'b0) late++;
        end
        n_cmp++;
        if (cnt !== 8'd1 || late != 0) begin
            n_err++;
            $display("FAIL slip_settle: cnt=%0d early_lock=%0d, required 1 0", cnt, late);
        end
        n_cmp++;
        if (lock !== 1'b1) begin
            n_err++;
            $display("FAIL slip_relock: lock=%b after 64 post-settle samples, required 1", lock);
        end
    endtask

    // Locked: 15 bad headers per window for three windows keeps lock.
    task automatic test_locked_tolerate();
        int drops;
        int slips;
        drops = 0;
        slips = 0;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 64; i++) begin
                send((i >= 49) ? 2'b11 : 2'b01, 1'b1);
                if (lock !== 1'b1) drops++;
                if (bs !== 1'b0) slips++;
            end
        end
        n_cmp++;
        if (drops != 0 || slips != 0) begin
            n_err++;
            $display("FAIL locked_15_bad: lock low %0d cycles, bitslip %0d cycles, required 0 0", drops, slips);
        end
    endtask

    // Locked: 16th bad header coincides with the 64th sample; loss wins.
    task automatic test_locked_loss();
        for (int i = 0; i < 63; i++) send((i >= 48) ? 2'b00 : 2'b10, 1'b1);
        n_cmp++;
        if (lock !== 1'b1) begin
            n_err++;
            $display("FAIL loss_before: lock=%b after 15 bad headers, required 1", lock);
        end
        send(2'b00, 1'b1);
        n_cmp++;
        if (lock !== 1'b0 || bs !== 1'b0) begin
            n_err++;
            $display("FAIL loss_drop: lock=%b bs=%b, required 0 0", lock, bs);
        end
        send(2'b01, 1'b1);
        n_cmp++;
        if (bs !== 1'b1 || cnt !== 8'd2) begin
            n_err++;
            $display("FAIL loss_slip: bs=%b cnt=%0d, required 1 2", bs, cnt);
        end
        send(2'b01, 1'b1);
        n_cmp++;
        if (bs !== 1'b0) begin
            n_err++;
            $display("FAIL loss_pulse_width: bs=%b, required 0", bs);
        end
    endtask

    // Valid toggling: 64 good headers spread over 128 cycles; bad headers on idle cycles ignored.
    task automatic test_valid_toggle();
        do_reset();
        for (int i = 1; i <= 127; i++) begin
            if (i % 2 == 0) send(2'b01, 1'b1);
            else            send(2'b11, 1'b0);
        end
        n_cmp++;
        if (lock !== 1'b0 || cnt !== 8'd0) begin
            n_err++;
            $display("FAIL toggle_127: lock=%b cnt=%0d, required 0 0", lock, cnt);
        end
        send(2'b10, 1'b1);
        n_cmp++;
        if (lock !== 1'b1) begin
            n_err++;
            $display("FAIL toggle_128: lock=%b, required 1", lock);
        end
    endtask

    // Constant 2'b00: one slip every 11 cycles, 300 slips, count saturates.
    task automatic test_saturate();
        int pulses;
        do_reset();
        pulses = 0;
        for (int e = 1; e <= 3300; e++) begin
            send(2'b00, 1'b1);
            if (bs === 1'b1) pulses++;
            if (e == 2790) begin
                n_cmp++;
                if (cnt !== 8'd254) begin
                    n_err++;
                    $display("FAIL sat_254: cnt=%0d, required 254", cnt);
                end
            end
        end
        n_cmp++;
        if (cnt !== 8'd255) begin
            n_err++;
            $display("FAIL sat_255: cnt=%0d, required 255", cnt);
        end
        n_cmp++;
        if (pulses != 300) begin
            n_err++;
            $display("FAIL sat_pulses: bitslip pulses=%0d, required 300", pulses);
        end
    endtask

    // Reset asserted in the middle of a 4-cycle bitslip pulse clears outputs without a clock edge.
    task automatic test_reset_mid_slip();
        do_reset();
        send(2'b00, 1'b1);           // SLIP entry
        send(2'b00, 1'b1);           // pulse cycle 1
        send(2'b00, 1'b1);           // pulse cycle 2
        n_cmp++;
        if (bs4 !== 1'b1 || cnt4 !== 8'd1 || bs !== 1'b0) begin
            n_err++;
            $display("FAIL midslip_pre: bs4=%b cnt4=%0d bs=%b, required 1 1 0", bs4, cnt4, bs);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bs4, lock4, cnt4} !== 10'd0 || cnt !== 8'd0) begin
            n_err++;
            $display("FAIL midslip_reset: bs4=%b lock4=%b cnt4=%0d cnt=%0d, required 0 0 0 0",
                     bs4, lock4, cnt4, cnt);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_slip();
        test_locked_tolerate();
        test_locked_loss();
        test_valid_toggle();
        test_saturate();
        test_reset_mid_slip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/eth_phy_10g_rx_block_lock.md
ETH_PHY_10G_RX_BLOCK_LOCK -- requirements
Module: eth_phy_10g_rx_block_lock

Interface
REQ-001 SHALL have parameter HDR_WIDTH, default 2, sync header width; only 2 is legal, other values SHALL cause an elaboration error.
REQ-002 SHALL have parameter BITSLIP_HIGH_CYCLES, default 1, bitslip pulse width in clk cycles (legal 1..255).
REQ-003 SHALL have parameter BITSLIP_LOW_CYCLES, default 8, post-slip settle time in clk cycles (legal 0..255).
REQ-004 SHALL have port clk  input  1  datapath clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 SHALL have port serdes_rx_hdr  input  HDR_WIDTH  sync header of the current 66b block, as fed to the 10GBASE-R decoder.
REQ-007 SHALL have port serdes_rx_hdr_valid  input  1  header qualifier; low cycles (gearbox pause) are not counted.
REQ-008 SHALL have port serdes_rx_bitslip  output  1  request to the SERDES/gearbox to slip alignment by one bit.
REQ-009 SHALL have port rx_block_lock  output  1  block lock status.
REQ-010 SHALL have port rx_slip_count  output  8  saturating count of slips issued since reset.

Function
REQ-011 A header SHALL be valid when equal to 2'b01 or 2'b10; 2'b00 and 2'b11 SHALL be invalid.
REQ-012 A header SHALL be sampled only in a cycle with serdes_rx_hdr_valid=1 and FSM in UNLOCKED or LOCKED.
REQ-013 FSM states SHALL be UNLOCKED, LOCKED, SLIP, SLIP_WAIT; counters sh_cnt (7 bit, 0..64) and sh_invalid_cnt (5 bit, 0..16).
REQ-014 UNLOCKED, valid header: sh_cnt increments; when the sample makes sh_cnt reach 64, next state LOCKED, rx_block_lock=1 from the next cycle, both counters cleared.
REQ-015 UNLOCKED, invalid header: next state SLIP, counters cleared.
REQ-016 LOCKED, any sampled header: sh_cnt increments; invalid header also increments sh_invalid_cnt.
REQ-017 LOCKED: when a sample makes sh_invalid_cnt reach 16, next state SLIP, rx_block_lock=0 from the next cycle, counters cleared; this SHALL take precedence over window completion in the same cycle.
REQ-018 LOCKED: when a sample makes sh_cnt reach 64 with sh_invalid_cnt<16, both counters SHALL clear and lock SHALL be retained.
REQ-019 SLIP: serdes_rx_bitslip=1 for exactly BITSLIP_HIGH_CYCLES cycles starting the cycle after SLIP entry, rx_slip_count increments once (saturating at 255), then SLIP_WAIT.
REQ-020 SLIP_WAIT: serdes_rx_bitslip=0, headers ignored for BITSLIP_LOW_CYCLES cycles (0 = straight through), then UNLOCKED with counters cleared.
REQ-021 rx_block_lock SHALL be 1 only in LOCKED; all outputs SHALL be registered.
REQ-022 serdes_rx_hdr_valid=0 SHALL freeze counters and FSM in UNLOCKED/LOCKED; SLIP/SLIP_WAIT timers SHALL run regardless of it.

Reset
REQ-023 rst_n=0 SHALL asynchronously force UNLOCKED, counters 0, serdes_rx_bitslip=0, rx_block_lock=0, rx_slip_count=0, including mid-SLIP (pulse truncated immediately).
REQ-024 After rst_n deasserts, the first header SHALL be sampled on the first rising edge with rst_n=1 and serdes_rx_hdr_valid=1.

Verification
REQ-025 64 consecutive 2'b01 headers, valid=1 -> rx_block_lock 0 through the 64th sample edge, 1 one cycle later; bitslip never asserted.
REQ-026 63 valid headers then 2'b11 -> bitslip high 1 cycle, rx_slip_count=1, headers ignored 8 cycles, then 64 valid headers achieve lock.
REQ-027 Locked, 15 invalid among a 64-header window, repeated 3 windows -> rx_block_lock stays 1, no bitslip.
REQ-028 Locked, 16 invalid within one window (16th equals the 64th sample) -> rx_block_lock drops next cycle, one bitslip pulse, rx_slip_count increments.
REQ-029 Unlocked, valid toggling 1/0 every cycle with 64 valid headers -> lock after 128 cycles; constant 2'b00 for 300 slips -> rx_slip_count saturates at 255.
REQ-030 rst_n asserted during the bitslip pulse with BITSLIP_HIGH_CYCLES=4 -> bitslip, lock, rx_slip_count all 0 immediately without a clock edge.
